instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the first instruction-memory word written.
REQ-002 Parameter DEPTH, default 64, instruction-memory capacity in words (power of two, 2..1024).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; begins a new program load.
REQ-006 in_valid  input  1  producer has a valid instruction descriptor.
REQ-007 in_ready  output  1  loader accepts the descriptor this cycle.
REQ-008 op_sel  input  3  operation: 0 R-format, 1 lw, 2 sw, 3 beq, 4 bgtzal, 5 brnv, 6-7 illegal.
REQ-009 rs, rt, rd, shamt  input  5 each  register and shift fields.
REQ-010 funct  input  6  R-format function field.
REQ-011 imm  input  16  immediate / branch offset.
REQ-012 in_last  input  1  descriptor is the final instruction of the program.
REQ-013 imem_we  output  1  instruction-memory write request.
REQ-014 imem_ready  input  1  memory accepts the write this cycle.
REQ-015 imem_addr  output  32  byte write address.
REQ-016 imem_wdata  output  32  encoded instruction word.
REQ-017 busy  output  1  load in progress.
REQ-018 done  output  1  program load complete (level, held until next start).
REQ-019 word_count  output  11  words written in the current load.
REQ-020 err_illegal, err_overflow  output  1 each  sticky error flags.

Function
REQ-021 Encoding: opcodes R 6'b000000, lw 6'b100011, sw 6'b101011, beq 6'b000100, bgtzal 6'b100001, brnv 6'b010100.
REQ-022 R-format word = {opcode, rs, rt, rd, shamt, funct}; all other legal ops = {opcode, rs, rt, imm}.
REQ-023 FSM states IDLE, LOAD, DRAIN, DONE; IDLE->LOAD on start; LOAD->DRAIN on accepting an in_last descriptor; DRAIN->DONE when the output register empties; start in DONE->LOAD.
REQ-024 start while in LOAD or DRAIN is ignored.
REQ-025 On start: imem_addr pointer := BASE_ADDR, word_count := 0, done := 0, both error flags cleared.
REQ-026 One-entry output register; imem_we = register valid; register holds addr/data stable until imem_ready.
REQ-027 in_ready = (state == LOAD) && (!imem_we || imem_ready); accept and write-out in the same cycle permitted, giving one word per cycle throughput.
REQ-028 Latency: accepted descriptor appears on imem_wdata/imem_we the following cycle.
REQ-029 Each completed write (imem_we && imem_ready) increments imem_addr pointer by 4 and word_count by 1.
REQ-030 Illegal op_sel: descriptor accepted, no word written, err_illegal set; if in_last, FSM still advances to DRAIN.
REQ-031 Overflow: accepting a legal descriptor when DEPTH words already written or queued drops it, sets err_overflow, and moves FSM to DRAIN.
REQ-032 busy = state in {LOAD, DRAIN}; done = state == DONE.

Reset
REQ-033 Asynchronous assertion of rst_n low forces state IDLE, imem_we 0, imem_addr BASE_ADDR, imem_wdata 0, word_count 0, done 0, busy 0, in_ready 0, error flags 0, regardless of operation in progress; a pending write is discarded.
REQ-034 Deassertion takes effect at the next clk edge; no start is honoured in the deassertion cycle's edge only if rst_n is still low.

Structure
REQ-035 Shared package holds the six opcode constants, the op_sel enumeration and the FSM state type.
REQ-036 One combinational sub-module, instr_pack, maps descriptor to 32-bit word plus illegal flag.

Verification
REQ-037 start, lw rs=2 rt=3 imm=16'h0004, in_last, imem_ready=1 -> next cycle imem_wdata 32'h8C43_0004 at addr 0, done two cycles later, word_count 1.
REQ-038 R add rs=1 rt=2 rd=3 shamt=0 funct=6'h20 then beq rs=1 rt=2 imm=16'hFFFF back-to-back -> 32'h0022_1820 @0, 32'h1022_FFFF @4, one per cycle.
REQ-039 imem_ready low 3 cycles with descriptor pending -> in_ready 0, imem_addr/wdata stable, no increment until ready.
REQ-040 op_sel=7 with in_last -> no imem_we, err_illegal 1, done asserted.
REQ-041 DEPTH=4, five legal descriptors -> four writes (addr 0..12), fifth dropped, err_overflow 1, done.
REQ-042 rst_n low mid-load with imem_we high -> all outputs to reset values immediately, no further writes.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// -----------------------------------------------------------------------------
// instr_loader_pkg
//   Shared definitions for the instruction loader:
//     - the six primary opcode constants of the supported instruction subset
//     - op_sel_e : descriptor operation selector (values 6/7 are illegal)
//     - state_e  : loader control state
//     - opcode_of: opcode lookup for a legal operation selector
// -----------------------------------------------------------------------------
package instr_loader_pkg;

    localparam logic [5:0] OPC_R      = 6'b000000;
    localparam logic [5:0] OPC_LW     = 6'b100011;
    localparam logic [5:0] OPC_SW     = 6'b101011;
    localparam logic [5:0] OPC_BEQ    = 6'b000100;
    localparam logic [5:0] OPC_BGTZAL = 6'b100001;
    localparam logic [5:0] OPC_BRNV   = 6'b010100;

    typedef enum logic [2:0] {
        OP_R      = 3'd0,
        OP_LW     = 3'd1,
        OP_SW     = 3'd2,
        OP_BEQ    = 3'd3,
        OP_BGTZAL = 3'd4,
        OP_BRNV   = 3'd5,
        OP_ILL6   = 3'd6,
        OP_ILL7   = 3'd7
    } op_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Illegal selectors map to all-zero; callers gate on the illegal flag.
    function automatic logic [5:0] opcode_of(input op_sel_e op);
        logic [5:0] opc;
        opc = '0;
        case (op)
            OP_R:      opc = OPC_R;
            OP_LW:     opc = OPC_LW;
            OP_SW:     opc = OPC_SW;
            OP_BEQ:    opc = OPC_BEQ;
            OP_BGTZAL: opc = OPC_BGTZAL;
            OP_BRNV:   opc = OPC_BRNV;
            default:   opc = '0;
        endcase
        return opc;
    endfunction

endpackage : instr_loader_pkg

// File: rtl/instr_loader_pack.sv
// -----------------------------------------------------------------------------
// instr_pack
//   Purely combinational encoder: turns one instruction descriptor into a
//   32-bit instruction word and flags selectors outside the supported set.
//
//   Ports
//     op_sel  in   3  operation selector (op_sel_e encoding)
//     rs      in   5  source register
//     rt      in   5  second source / target register
//     rd      in   5  destination register (R-format only)
//     shamt   in   5  shift amount (R-format only)
//     funct   in   6  function field (R-format only)
//     imm     in  16  immediate / branch offset (I-format only)
//     word    out 32  encoded instruction (zero when illegal)
//     illegal out  1  op_sel is not one of the six supported operations
// -----------------------------------------------------------------------------
module instr_pack
    import instr_loader_pkg::*;
(
    input  logic [2:0]  op_sel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    op_sel_e    op;
    logic [5:0] opcode;
    logic       r_format;

    assign op = op_sel_e'(op_sel);

    always_comb begin
        opcode   = opcode_of(op);
        r_format = 1'b0;
        illegal  = 1'b0;
        case (op)
            OP_R:                                     r_format = 1'b1;
            OP_LW, OP_SW, OP_BEQ, OP_BGTZAL, OP_BRNV: r_format = 1'b0;
            default:                                  illegal  = 1'b1;
        endcase
    end

    always_comb begin
        word = '0;
        if (!illegal) begin
            if (r_format) begin
                word = {opcode, rs, rt, rd, shamt, funct};
            end else begin
                word = {opcode, rs, rt, imm};
            end
        end
    end

endmodule : instr_pack

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//   Accepts a stream of instruction descriptors, encodes each into a 32-bit
//   word and writes the words to consecutive instruction-memory addresses
//   starting at BASE_ADDR. A single output register decouples the producer
//   from the memory while still allowing one word per cycle.
//
//   Parameters
//     BASE_ADDR  byte address of the first word written
//     DEPTH      memory capacity in words (power of two, 2..1024)
//
//   Ports
//     clk, rst_n            clock, asynchronous active-low reset
//     start                 one-cycle pulse, begins a load (IDLE/DONE only)
//     in_valid / in_ready   descriptor handshake
//     op_sel, rs, rt, rd,
//     shamt, funct, imm     descriptor fields
//     in_last               descriptor is the last of the program
//     imem_we / imem_ready  memory write handshake
//     imem_addr, imem_wdata write address / data, stable while stalled
//     busy, done            load in progress / load complete (level)
//     word_count            words written in the current load
//     err_illegal           an illegal op_sel was seen (sticky until start)
//     err_overflow          a legal descriptor was dropped for lack of room
// -----------------------------------------------------------------------------
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op_sel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic        in_last,
    output logic        imem_we,
    input  logic        imem_ready,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        busy,
    output logic        done,
    output logic [10:0] word_count,
    output logic        err_illegal,
    output logic        err_overflow
);

    state_e      state;
    state_e      state_next;

    logic        out_valid;
    logic [31:0] out_data;
    logic [31:0] ptr;
    logic [10:0] count;
    logic        ill_q;
    logic        ovf_q;

    logic [31:0] pack_word;
    logic        pack_illegal;

    logic        ready_c;
    logic        accept;
    logic        push;
    logic        drop;
    logic        write_done;
    logic        start_load;
    logic        full;
    logic [11:0] queued;

    instr_pack u_pack (
        .op_sel  (op_sel),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .shamt   (shamt),
        .funct   (funct),
        .imm     (imm),
        .word    (pack_word),
        .illegal (pack_illegal)
    );

    assign write_done = out_valid && imem_ready;

    // Words already written plus the one held in the output register; the
    // word completing this cycle is still counted as queued here.
    assign queued = {1'b0, count} + {11'b0, out_valid};
    assign full   = (queued >= 12'(DEPTH));

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready_c    = 1'b0;
        start_load = 1'b0;
        accept     = 1'b0;
        push       = 1'b0;
        drop       = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    start_load = 1'b1;
                    state_next = ST_LOAD;
                end
            end

            ST_LOAD: begin
                ready_c = !out_valid || imem_ready;
                accept  = in_valid && ready_c;
                push    = accept && !pack_illegal && !full;
                drop    = accept && !pack_illegal && full;
                if (accept && (in_last || drop)) begin
                    state_next = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                // Leave as soon as the register is empty after this edge.
                if (!out_valid || imem_ready) begin
                    state_next = ST_DONE;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: output register, address pointer, counters, error flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            ptr       <= BASE_ADDR;
            count     <= '0;
            ill_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (start_load) begin
                ptr   <= BASE_ADDR;
                count <= '0;
                ill_q <= 1'b0;
                ovf_q <= 1'b0;
            end else begin
                if (write_done) begin
                    ptr   <= ptr + 32'd4;
                    count <= count + 11'd1;
                end
                if (accept && pack_illegal) begin
                    ill_q <= 1'b1;
                end
                if (drop) begin
                    ovf_q <= 1'b1;
                end
            end

            // Refill and drain can coincide, keeping one word per cycle.
            if (push) begin
                out_valid <= 1'b1;
                out_data  <= pack_word;
            end else if (write_done) begin
                out_valid <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready     = ready_c;
    assign imem_we      = out_valid;
    assign imem_addr    = ptr;
    assign imem_wdata   = out_data;
    assign busy         = (state == ST_LOAD) || (state == ST_DRAIN);
    assign done         = (state == ST_DONE);
    assign word_count   = count;
    assign err_illegal  = ill_q;
    assign err_overflow = ovf_q;

endmodule : instr_loader

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
//   Directed scenarios followed by randomized programs for instr_loader,
//   checked against a program-level reference model.
// -----------------------------------------------------------------------------
module tb_instr_loader;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op_sel = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [5:0]  funct = '0;
    logic [15:0] imm = '0;
    logic        in_last = 1'b0;
    logic        imem_we;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic [10:0] word_count;
    logic        err_illegal;
    logic        err_overflow;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];

    logic [2:0]  p_op   [8];
    logic [4:0]  p_rs   [8];
    logic [4:0]  p_rt   [8];
    logic [4:0]  p_rd   [8];
    logic [4:0]  p_sh   [8];
    logic [5:0]  p_fn   [8];
    logic [15:0] p_imm  [8];

    instr_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op_sel       (op_sel),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .shamt        (shamt),
        .funct        (funct),
        .imm          (imm),
        .in_last      (in_last),
        .imem_we      (imem_we),
        .imem_ready   (imem_ready),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .busy         (busy),
        .done         (done),
        .word_count   (word_count),
        .err_illegal  (err_illegal),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    // Record every completed memory write.
    always @(negedge clk) begin
        if (rst_n && imem_we && imem_ready) begin
            wq_addr.push_back(imem_addr);
            wq_data.push_back(imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [2:0] op, input logic [4:0] s,
                                               input logic [4:0] t, input logic [4:0] d,
                                               input logic [4:0] sh, input logic [5:0] fn,
                                               input logic [15:0] im);
        logic [5:0] opc;
        case (op)
            3'd0:    opc = 6'b000000;
            3'd1:    opc = 6'b100011;
            3'd2:    opc = 6'b101011;
            3'd3:    opc = 6'b000100;
            3'd4:    opc = 6'b100001;
            3'd5:    opc = 6'b010100;
            default: opc = 6'b000000;
        endcase
        if (op == 3'd0) return {opc, s, t, d, sh, fn};
        return {opc, s, t, im};
    endfunction

    task automatic drive_desc(input logic [2:0] op, input logic [4:0] s, input logic [4:0] t,
                              input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn,
                              input logic [15:0] im, input logic last);
        in_valid = 1'b1;
        op_sel = op; rs = s; rt = t; rd = d; shamt = sh; funct = fn; imm = im;
        in_last = last;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_we"},    imem_we, 0);
        chk({tag, "_addr"},  imem_addr, BASE);
        chk({tag, "_wdata"}, imem_wdata, 0);
        chk({tag, "_wc"},    word_count, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_rdy"},   in_ready, 0);
        chk({tag, "_ill"},   err_illegal, 0);
        chk({tag, "_ovf"},   err_overflow, 0);
    endtask

    // Runs the program held in p_* (n descriptors, last one flagged in_last).
    task automatic run_program(input string tag, input int n, input int rdy_pct,
                               input int vld_pct, input bit rand_start);
        logic [31:0] exp_w[$];
        int          n_acc;
        bit          e_ill, e_ovf, got_done;
        int          idx;
        logic        p_we, p_rdy;
        logic [31:0] p_a, p_d;

        exp_w.delete();
        n_acc = 0; e_ill = 0; e_ovf = 0;
        for (int i = 0; i < n; i++) begin
            n_acc = i + 1;
            if (p_op[i] > 3'd5) begin
                e_ill = 1;
            end else if (exp_w.size() >= DEPTH) begin
                e_ovf = 1;
                break;
            end else begin
                exp_w.push_back(model_word(p_op[i], p_rs[i], p_rt[i], p_rd[i],
                                           p_sh[i], p_fn[i], p_imm[i]));
            end
        end

        wq_addr.delete(); wq_data.delete();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        idx = 0; got_done = 0; p_we = 0; p_rdy = 1; p_a = '0; p_d = '0;
        for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
            if (idx < n_acc && $urandom_range(0, 99) < vld_pct) begin
                drive_desc(p_op[idx], p_rs[idx], p_rt[idx], p_rd[idx], p_sh[idx],
                           p_fn[idx], p_imm[idx], (idx == n - 1));
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
                op_sel = 3'($urandom); imm = 16'($urandom);
            end
            imem_ready = ($urandom_range(0, 99) < rdy_pct);
            start = rand_start && ($urandom_range(0, 9) == 0);
            @(negedge clk);
            if (imem_we && !imem_ready) chk({tag, "_stall_rdy"}, in_ready, 0);
            if (p_we && !p_rdy) begin
                chk({tag, "_hold_we"},   imem_we, 1);
                chk({tag, "_hold_addr"}, imem_addr, p_a);
                chk({tag, "_hold_data"}, imem_wdata, p_d);
            end
            p_we = imem_we; p_rdy = imem_ready; p_a = imem_addr; p_d = imem_wdata;
            if (in_valid && in_ready) idx++;
            got_done = done;
            if (!got_done) begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0;

        chk({tag, "_done"},   got_done, 1);
        chk({tag, "_acc"},    idx, n_acc);
        chk({tag, "_nwr"},    wq_addr.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < wq_addr.size(); i++) begin
            chk({tag, "_addr"}, wq_addr[i], BASE + 32'(4 * i));
            chk({tag, "_data"}, wq_data[i], exp_w[i]);
        end
        chk({tag, "_wc"},     word_count, exp_w.size());
        chk({tag, "_ill"},    err_illegal, e_ill);
        chk({tag, "_ovf"},    err_overflow, e_ovf);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_rdy"},    in_ready, 0);
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk); chk_reset("rst");
        @(posedge clk); #1; rst_n = 1'b1;

        // Single lw, latency and completion
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        drive_desc(3'd1, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0004, 1'b1); imem_ready = 1'b1;
        @(negedge clk); chk("lw_busy", busy, 1); chk("lw_rdy", in_ready, 1);
        chk("lw_we0", imem_we, 0);
        @(posedge clk); #1; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk); chk("lw_we", imem_we, 1); chk("lw_data", imem_wdata, 32'h8C43_0004);
        chk("lw_addr", imem_addr, 32'h0); chk("lw_done0", done, 0);
        @(posedge clk); #1;
        @(negedge clk); chk("lw_done", done, 1); chk("lw_wc", word_count, 1);
        chk("lw_we_off", imem_we, 0); chk("lw_busy_off", busy, 0); chk("lw_ptr", imem_addr, 32'h4);

        // R add then beq back to back
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        drive_desc(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0000, 1'b0);
        @(negedge clk); chk("bb_done_clr", done, 0); chk("bb_wc_clr", word_count, 0);
        chk("bb_rdy0", in_ready, 1); chk("bb_addr_clr", imem_addr, 32'h0);
        @(posedge clk); #1; drive_desc(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 1'b1);
        @(negedge clk); chk("bb_rdy1", in_ready, 1); chk("bb_we0", imem_we, 1);
        chk("bb_data0", imem_wdata, 32'h0022_1820); chk("bb_addr0", imem_addr, 32'h0);
        @(posedge clk); #1; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk); chk("bb_we1", imem_we, 1); chk("bb_data1", imem_wdata, 32'h1022_FFFF);
        chk("bb_addr1", imem_addr, 32'h4); chk("bb_wc1", word_count, 1);
        @(posedge clk); #1;
        @(negedge clk); chk("bb_done", done, 1); chk("bb_wc", word_count, 2);

        // Memory stall for three cycles (a start during the stall is ignored)
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        drive_desc(3'd2, 5'd5, 5'd6, 5'd0, 5'd0, 6'd0, 16'h1234, 1'b0); imem_ready = 1'b0;
        @(negedge clk); chk("st_rdy_first", in_ready, 1);
        @(posedge clk); #1; drive_desc(3'd4, 5'd7, 5'd0, 5'd0, 5'd0, 6'd0, 16'h00FF, 1'b1);
        for (int k = 0; k < 3; k++) begin
            start = (k == 1);
            @(negedge clk);
            chk("st_rdy", in_ready, 0); chk("st_we", imem_we, 1);
            chk("st_addr", imem_addr, 32'h0); chk("st_data", imem_wdata, 32'hACA6_1234);
            chk("st_wc", word_count, 0);
            @(posedge clk); #1;
        end
        start = 1'b0; imem_ready = 1'b1;
        @(negedge clk); chk("st_rel_rdy", in_ready, 1); chk("st_rel_addr", imem_addr, 32'h0);
        @(posedge clk); #1; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk); chk("st_data2", imem_wdata, 32'h84E0_00FF);
        chk("st_addr2", imem_addr, 32'h4); chk("st_wc1", word_count, 1);
        @(posedge clk); #1;
        @(negedge clk); chk("st_done", done, 1); chk("st_wc2", word_count, 2);

        // Illegal op with in_last
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        drive_desc(3'd7, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'h0001, 1'b1);
        @(negedge clk); chk("il_rdy", in_ready, 1); chk("il_flag0", err_illegal, 0);
        @(posedge clk); #1; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk); chk("il_we", imem_we, 0); chk("il_flag", err_illegal, 1);
        @(posedge clk); #1;
        @(negedge clk); chk("il_done", done, 1); chk("il_wc", word_count, 0);
        chk("il_we2", imem_we, 0); chk("il_flag2", err_illegal, 1);

        // Overflow: five legal descriptors into four words
        for (int i = 0; i < 5; i++) begin
            p_op[i] = 3'd1; p_rs[i] = 5'(i); p_rt[i] = 5'(i + 1); p_rd[i] = '0;
            p_sh[i] = '0; p_fn[i] = '0; p_imm[i] = 16'(16'h0100 + i);
        end
        run_program("ovf", 5, 100, 100, 1'b0);
        chk("ovf_flag", err_overflow, 1);

        // Asynchronous reset mid-load with a pending write
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        drive_desc(3'd1, 5'd9, 5'd10, 5'd0, 5'd0, 6'd0, 16'hBEEF, 1'b0); imem_ready = 1'b0;
        @(posedge clk); #1; drive_desc(3'd2, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h0008, 1'b0);
        @(negedge clk); chk("ar_we_pre", imem_we, 1);
        #2 rst_n = 1'b0;
        #1 chk_reset("ar");
        wq_addr.delete(); wq_data.delete();
        imem_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk); chk("ar_nowr", wq_addr.size(), 0);
        @(posedge clk); #1;
        @(negedge clk); chk_reset("ar_post");

        // Randomized programs
        for (int r = 0; r < 30; r++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                p_op[i]  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(6, 7))
                                                       : 3'($urandom_range(0, 5));
                p_rs[i]  = 5'($urandom); p_rt[i] = 5'($urandom); p_rd[i] = 5'($urandom);
                p_sh[i]  = 5'($urandom); p_fn[i] = 6'($urandom); p_imm[i] = 16'($urandom);
            end
            run_program("rnd", n, (r % 3 == 0) ? 100 : 60, (r % 2 == 0) ? 100 : 70, (r % 2 == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_instr_loader
